axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
AXI4-Lite responder exposing four 32-bit memory-mapped registers. It is the slave-side endpoint that the interconnect's master ports drive. It provides two read-write control registers to downstream logic, one read-only live status input and one read-only write counter. Independent write and read state machines allow one read and one write to proceed concurrently.

Parameters:
DATA_WIDTH, 32, register and data bus width (multiple of 8)
ADDR_WIDTH, 8, AXI address width
RESP_WIDTH, 2, bresp/rresp width
BASE_ADDR, 8'h00, register window base; bits [3:0] must be zero

Ports:
s_axi_aclk  in  1  single clock
s_axi_areset  in  1  synchronous reset, active-high
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
status_in  in  DATA_WIDTH  live status, readable at 0x8
ctrl_q  out  DATA_WIDTH  CTRL register value
data_q  out  DATA_WIDTH  DATA register value

Behaviour:
- Reset (s_axi_areset=1 at posedge): all outputs and registers 0; awready=wready=arready=0 in the reset cycle, 1 in the first cycle after reset is released. Reset mid-transaction abandons it silently; no response is issued.
- Map (offset = addr[3:2], addr[1:0] ignored): 0x0 CTRL RW, 0x4 DATA RW, 0x8 STATUS RO (=status_in), 0xC WCOUNT RO. addr[ADDR_WIDTH-1:4] != BASE_ADDR[ADDR_WIDTH-1:4] is a decode miss.
- Responses: OKAY=0, SLVERR=2, DECERR=3 (package constants).
- Write FSM, states W_IDLE, W_GOT_AW, W_GOT_W, W_RESP:
  - W_IDLE: awready=wready=1. Both handshakes in the same cycle -> W_RESP. AW only -> W_GOT_AW. W only -> W_GOT_W. The captured address or data/strobe is latched.
  - W_GOT_AW: awready=0, wready=1; W handshake -> W_RESP. W_GOT_W is the mirror case.
  - The register update commits on the cycle the FSM enters W_RESP. bvalid=1 from the next cycle, i.e. 1 cycle after the later handshake. bvalid and bresp are held until bready, then the FSM returns to W_IDLE with awready=wready=1 on the following cycle. awready=wready=0 throughout W_RESP.
  - CTRL and DATA: byte i updated only if wstrb[i]; bresp=OKAY. STATUS or WCOUNT target: no update, bresp=SLVERR. Decode miss: bresp=DECERR.
  - WCOUNT increments by 1 on every OKAY write and wraps from all-ones to 0. A write with wstrb=0 still counts as OKAY.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On handshake, rdata and rresp are registered and rvalid=1 next cycle, giving 1-cycle latency.
  - R_DATA: arready=0; rdata, rresp and rvalid are held until rready, then R_IDLE.
  - Decode miss: rdata=0, rresp=DECERR. STATUS returns status_in as sampled at the AR handshake cycle.
- Simultaneous read and write to the same register: a read whose AR handshake occurs in the write-commit cycle returns the pre-write value.
- ctrl_q and data_q are direct register outputs; they change the cycle after the commit.

Optional Feature:
- Macro AXIL_REG_IRQ_EN.
- Defined: adds output irq_pulse (1 bit, reset 0), asserted for exactly one cycle in the cycle after each OKAY write to CTRL whose written value has bit 0 = 1.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Package axil_reg_pkg holds:
  - response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - register offset constants REG_CTRL, REG_DATA, REG_STATUS, REG_WCOUNT;
  - enums wr_state_t and rd_state_t.
- One natural sub-module, axil_reg_decode: combinational address-to-{hit, index, writable} decode, instanced twice (AW and AR paths).

Test Plan:
- Reset, then AW+W together to 0x0 with data 0xA5A5_0001 and wstrb 0xF -> bvalid 1 cycle later with bresp=0. ctrl_q=0xA5A5_0001; WCOUNT read returns 1.
- W issued 3 cycles before AW to 0x4 with data 0x1122_3344 and wstrb 0x5 -> data_q=0x0022_0044 (from 0). The response arrives 1 cycle after the AW handshake.
- Write to 0x8 -> bresp=SLVERR, WCOUNT unchanged. Read from 0x20 -> rdata=0, rresp=DECERR.
- Hold status_in=0xDEAD_BEEF, read 0x8 with rready low for 4 cycles -> rvalid, rdata and rresp stable throughout; arready=0 until the rready handshake.
- Preload WCOUNT to 0xFFFF_FFFE via 2 fewer writes (force in bench), then 2 OKAY writes -> reads return 0xFFFF_FFFF, then 0.
- Assert reset while bvalid=1 and bready=0 -> next cycle bvalid=0, ctrl_q=0, and all ready signals 1 one cycle after reset is released.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: response codes, register offsets and FSM state types shared by axil_reg_slave
package axil_reg_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_WCOUNT = 2'd3;
  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/axil_reg_decode.sv
// axil_reg_decode: combinational address decode into window hit, register index and writability
// Ports: addr in; hit = upper bits match BASE_ADDR, idx = addr[3:2], writable = hit on CTRL/DATA.
module axil_reg_decode
  import axil_reg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [1:0]            idx,
  output logic                  writable
);
  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];
  always_comb begin
    hit = addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    idx = addr[3:2];
    writable = hit && (idx == REG_CTRL || idx == REG_DATA);
  end
endmodule

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite slave with CTRL/DATA (RW), STATUS (RO live input) and WCOUNT (RO) registers
// Ports: s_axi_* AXI4-Lite slave (sync active-high reset s_axi_areset), status_in live status,
// ctrl_q/data_q register outputs. Macro AXIL_REG_IRQ_EN adds irq_pulse on OKAY CTRL writes with bit 0 set.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [DATA_WIDTH-1:0]   status_in,
`ifdef AXIL_REG_IRQ_EN
  output logic                    irq_pulse,
`endif
  output logic [DATA_WIDTH-1:0]   ctrl_q,
  output logic [DATA_WIDTH-1:0]   data_q
);
  localparam int SW = DATA_WIDTH / 8;
  wr_state_t w_state_q, w_state_d;
  rd_state_t r_state_q, r_state_d;
  logic rdy_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wcount_q, wcount_d, ctrl_d, data_d, rdata_q, rdata_d, merged;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, commit, aw_hit, aw_wr, ar_hit, ar_unused_wr;
  logic [1:0] aw_idx, ar_idx;
  // rdy_q holds all address/data readies low for the cycle right after a reset edge
  assign s_axi_awready = rdy_q && (w_state_q == W_IDLE || w_state_q == W_GOT_W);
  assign s_axi_wready  = rdy_q && (w_state_q == W_IDLE || w_state_q == W_GOT_AW);
  assign s_axi_arready = rdy_q && r_state_q == R_IDLE;
  assign s_axi_bvalid  = w_state_q == W_RESP;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = r_state_q == R_DATA;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  // awaddr_d/wdata_d/wstrb_d are the effective write operands: this cycle's beat or the latched one
  axil_reg_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_aw_dec (
    .addr(awaddr_d), .hit(aw_hit), .idx(aw_idx), .writable(aw_wr)
  );
  axil_reg_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_ar_dec (
    .addr(s_axi_araddr), .hit(ar_hit), .idx(ar_idx), .writable(ar_unused_wr)
  );
  always_comb begin
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs = s_axi_wvalid && s_axi_wready;
    awaddr_d = aw_hs ? s_axi_awaddr : awaddr_q;
    wdata_d = w_hs ? s_axi_wdata : wdata_q;
    wstrb_d = w_hs ? s_axi_wstrb : wstrb_q;
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:   w_state_d = aw_hs && w_hs ? W_RESP : aw_hs ? W_GOT_AW : w_hs ? W_GOT_W : W_IDLE;
      W_GOT_AW: if (w_hs) w_state_d = W_RESP;
      W_GOT_W:  if (aw_hs) w_state_d = W_RESP;
      W_RESP:   if (s_axi_bready) w_state_d = W_IDLE;
    endcase
    commit = w_state_d == W_RESP && w_state_q != W_RESP;
  end
  always_comb begin
    merged = aw_idx == REG_CTRL ? ctrl_q : data_q;
    for (int i = 0; i < SW; i++)
      if (wstrb_d[i]) merged[8*i +: 8] = wdata_d[8*i +: 8];
    ctrl_d = commit && aw_wr && aw_idx == REG_CTRL ? merged : ctrl_q;
    data_d = commit && aw_wr && aw_idx == REG_DATA ? merged : data_q;
    wcount_d = commit && aw_wr ? wcount_q + DATA_WIDTH'(1) : wcount_q;
    bresp_d = !commit ? bresp_q : !aw_hit ? RESP_WIDTH'(RESP_DECERR) :
              aw_wr ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
  end
  always_comb begin
    ar_hs = s_axi_arvalid && s_axi_arready;
    rdata_d = !ar_hs ? rdata_q : !ar_hit ? '0 :
              ar_idx == REG_CTRL ? ctrl_q : ar_idx == REG_DATA ? data_q :
              ar_idx == REG_STATUS ? status_in : wcount_q;
    rresp_d = !ar_hs ? rresp_q : ar_hit ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_DECERR);
    r_state_d = r_state_q == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (s_axi_rready ? R_IDLE : R_DATA);
  end
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdy_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ctrl_q    <= '0;
      data_q    <= '0;
      wcount_q  <= '0;
      bresp_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_q     <= 1'b1;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      wcount_q  <= wcount_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end
`ifdef AXIL_REG_IRQ_EN
  logic irq_pulse_q, irq_pulse_d;
  assign irq_pulse = irq_pulse_q;
  always_comb irq_pulse_d = commit && aw_wr && aw_idx == REG_CTRL && ctrl_d[0];
  always_ff @(posedge s_axi_aclk) irq_pulse_q <= s_axi_areset ? 1'b0 : irq_pulse_d;
`endif
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed plus randomized AXI4-Lite traffic checked against a register-map model
module tb_axil_reg_slave;
  logic s_axi_aclk = 1'b0;
  logic s_axi_areset = 1'b1;
  logic [7:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0, s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic [31:0] s_axi_wdata = '0, status_in = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, ctrl_q, data_q;
`ifdef AXIL_REG_IRQ_EN
  logic irq_pulse;
`endif
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_reg [2];
  logic [31:0] m_wcount;

  axil_reg_slave dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .status_in(status_in),
`ifdef AXIL_REG_IRQ_EN
    .irq_pulse(irq_pulse),
`endif
    .ctrl_q(ctrl_q), .data_q(data_q)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    if (a[7:4] != 4'h0) r = 2'd3;
    else if (a[3]) r = 2'd2;
    else begin
      for (int i = 0; i < 4; i++) if (s[i]) m_reg[a[2]][8*i +: 8] = d[8*i +: 8];
      m_wcount = m_wcount + 1;
      r = 2'd0;
    end
  endtask

  task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    r = a[7:4] != 4'h0 ? 2'd3 : 2'd0;
    d = a[7:4] != 4'h0 ? 32'h0 : a[3:2] == 2'd0 ? m_reg[0] : a[3:2] == 2'd1 ? m_reg[1] : a[3:2] == 2'd2 ? status_in : m_wcount;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_dly, input int w_dly,
                    output logic [1:0] resp, output logic bv);
    bit aw_done, w_done, aw_f, w_f;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid = !w_done && cyc >= w_dly;
      aw_f = s_axi_awvalid && s_axi_awready;
      w_f = s_axi_wvalid && s_axi_wready;
      @(posedge s_axi_aclk); #1;
      cyc++;
      aw_done |= aw_f;
      w_done |= w_f;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    bv = s_axi_bvalid;
    resp = s_axi_bresp;
  endtask

  task automatic ack();
    s_axi_bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    s_axi_bready = 1'b0;
    chk("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd);
    logic [1:0] r, er;
    logic bv;
    wr(a, d, s, awd, wd, r, bv);
    m_write(a, d, s, er);
    chk("bvalid_latency", 32'(bv), 32'd1);
    chk("bresp", 32'(r), 32'(er));
    ack();
    chk("ctrl_q", ctrl_q, m_reg[0]);
    chk("data_q", data_q, m_reg[1]);
  endtask

  task automatic rd(input logic [7:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
    bit done, stable;
    int cyc;
    done = 0; stable = 1; cyc = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!done && cyc < 40) begin
      done = s_axi_arready;
      @(posedge s_axi_aclk); #1;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    chk("rd_handshake", 32'(done), 32'd1);
    chk("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    for (int i = 0; i < hold; i++) begin
      @(posedge s_axi_aclk); #1;
      stable &= s_axi_rvalid && s_axi_rdata === d && s_axi_rresp === r && !s_axi_arready;
    end
    if (hold > 0) chk("rd_hold_stable", 32'(stable), 32'd1);
    s_axi_rready = 1'b1;
    @(posedge s_axi_aclk); #1;
    s_axi_rready = 1'b0;
    chk("rvalid_clear", 32'(s_axi_rvalid), 32'd0);
  endtask

  task automatic do_rd(input logic [7:0] a, input int hold);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    m_read(a, ed, er);
    rd(a, hold, d, r);
    chk("rdata", d, ed);
    chk("rresp", 32'(r), 32'(er));
  endtask

  initial begin
    logic [1:0] r;
    logic bv;
    logic [31:0] d, pre;
    logic [7:0] a;
    m_reg[0] = '0; m_reg[1] = '0; m_wcount = '0;
    @(posedge s_axi_aclk); #1;
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_ctrl_q", ctrl_q, 32'd0);
    chk("rst_data_q", data_q, 32'd0);
    s_axi_areset = 1'b0;
    @(posedge s_axi_aclk); #1;
    chk("post_rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    do_wr(8'h00, 32'hA5A5_0001, 4'hF, 0, 0);
    chk("ctrl_first", ctrl_q, 32'hA5A5_0001);
    do_rd(8'h0C, 0);
    do_wr(8'h04, 32'h1122_3344, 4'h5, 3, 0);
    chk("data_strb", data_q, 32'h0022_0044);
    do_wr(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_rd(8'h0C, 0);
    do_rd(8'h20, 0);
    status_in = 32'hDEAD_BEEF;
    do_rd(8'h08, 4);
    pre = m_reg[0];
    fork
      wr(8'h00, 32'h0BAD_F00D, 4'hF, 0, 0, r, bv);
      rd(8'h00, 0, d, r);
    join
    chk("same_cycle_read_old", d, pre);
    m_write(8'h00, 32'h0BAD_F00D, 4'hF, r);
    ack();
    chk("ctrl_after_race", ctrl_q, m_reg[0]);
    force dut.wcount_q = 32'hFFFF_FFFE;
    @(posedge s_axi_aclk); #1;
    release dut.wcount_q;
    m_wcount = 32'hFFFF_FFFE;
    do_wr(8'h04, 32'h0000_0000, 4'h0, 0, 1);
    do_rd(8'h0C, 0);
    chk("wcount_all_ones", m_wcount, 32'hFFFF_FFFF);
    do_wr(8'h00, 32'h1357_9BDF, 4'hA, 2, 0);
    do_rd(8'h0C, 0);
    chk("wcount_wrap", m_wcount, 32'h0);
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a[7:4] = 4'h0;
      status_in = $urandom;
      if ($urandom_range(0, 1) == 0) do_wr(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else do_rd(a, $urandom_range(0, 2));
    end
    do_rd(8'h0C, 0);
    wr(8'h00, 32'h1234_5678, 4'hF, 0, 0, r, bv);
    chk("pre_rst_bvalid", 32'(bv), 32'd1);
    repeat (2) @(posedge s_axi_aclk);
    #1;
    chk("bvalid_held", 32'(s_axi_bvalid), 32'd1);
    s_axi_areset = 1'b1;
    @(posedge s_axi_aclk); #1;
    s_axi_areset = 1'b0;
    chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("mid_rst_ctrl_q", ctrl_q, 32'd0);
    chk("mid_rst_data_q", data_q, 32'd0);
    chk("mid_rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    @(posedge s_axi_aclk); #1;
    chk("mid_rst_ready_after", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    chk("mid_rst_bvalid_after", 32'(s_axi_bvalid), 32'd0);
    m_reg[0] = '0; m_reg[1] = '0; m_wcount = '0;
    do_rd(8'h0C, 0);
    do_rd(8'h00, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
